// File: rtl/nic_pkg.sv
// Shared constants and types for the NIC register window and its two channel buffers.
package nic_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int VC_BIT_DEF     = 0;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

  // Status words carry the flag in the least significant bit, all else zero.
  function automatic logic [0:DATA_WIDTH_DEF-1] status_word(input logic flag);
    logic [0:DATA_WIDTH_DEF-1] w;
    w = '0;
    w[DATA_WIDTH_DEF-1] = flag;
    return w;
  endfunction

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry channel register with an EMPTY/FULL flag, loaded and drained by strobes.
//   state    | meaning
//   CH_EMPTY | slot free, load captures d
//   CH_FULL  | slot holds q, drain frees it (q keeps its value)
module nic_channel_buffer
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic [0:DATA_WIDTH-1] d,
  output logic [0:DATA_WIDTH-1] q,
  output logic                  full
);

  chan_state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CH_EMPTY;
      q     <= '0;
    end else begin
      case (state)
        CH_EMPTY: begin
          if (load) begin
            q     <= d;
            state <= CH_FULL;
          end
        end
        CH_FULL: begin
          if (drain) state <= CH_EMPTY;
        end
        default: state <= CH_EMPTY;
      endcase
    end
  end

  assign full = (state == CH_FULL);

endmodule

// File: rtl/nic_interface.sv
// NIC between the processor register window and a mesh router port; one-entry
// buffers each way, outbound injection gated by virtual-channel polarity.
module nic_interface
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int VC_BIT     = VC_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  logic                  rd_en;
  logic                  wr_en;
  logic                  in_load;
  logic                  in_drain;
  logic                  in_full;
  logic [0:DATA_WIDTH-1] in_buf;
  logic                  out_load;
  logic                  out_full;
  logic [0:DATA_WIDTH-1] out_buf;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // A drain and a router accept never coincide: the accept needs the slot empty.
  assign in_load  = net_si & net_ri;
  assign in_drain = rd_en & (addr == NIC_ADDR_IN_BUF);

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .drain (in_drain),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  // A write landing on the send edge sees the slot still full and is dropped.
  assign out_load = wr_en & (addr == NIC_ADDR_OUT_BUF);

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .drain (net_so),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  assign net_ri = ~in_full;
  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
  assign net_do = out_full ? out_buf : '0;

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out = in_buf;
        NIC_ADDR_IN_STAT:  d_out = status_word(in_full);
        NIC_ADDR_OUT_STAT: d_out = status_word(out_full);
        default:           d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_interface.sv
// Bench for nic_interface: directed scenarios plus randomized traffic against a buffer-level model.
module tb_nic_interface;

  localparam int DW = 64;
  localparam int VC = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [0:1]    addr = 2'b00;
  logic [0:DW-1] d_in = '0;
  logic [0:DW-1] d_out;
  logic          nicEn = 1'b0;
  logic          nicWrEn = 1'b0;
  logic          net_si = 1'b0;
  logic          net_ri;
  logic [0:DW-1] net_di = '0;
  logic          net_so;
  logic          net_ro = 1'b0;
  logic [0:DW-1] net_do;
  logic          net_polarity = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [0:DW-1] m_in_buf = '0;
  logic [0:DW-1] m_out_buf = '0;
  logic          m_in_full = 1'b0;
  logic          m_out_full = 1'b0;

  nic_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .VC_BIT(VC)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    net_polarity = ~net_polarity;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:DW-1] status(input logic f);
    logic [0:DW-1] w;
    w = '0;
    w[DW-1] = f;
    return w;
  endfunction

  function automatic logic exp_so();
    return m_out_full && net_ro && (m_out_buf[VC] == net_polarity);
  endfunction

  function automatic logic [0:DW-1] exp_dout();
    if (!nicEn || nicWrEn) return '0;
    case (addr)
      2'b00:   return m_in_buf;
      2'b01:   return status(m_in_full);
      2'b11:   return status(m_out_full);
      default: return '0;
    endcase
  endfunction

  // Buffer-level model: who may move a word on each edge.
  always @(posedge clk or posedge reset) begin : model
    logic drain_in, take_in, wr_out, send_out;
    if (reset) begin
      m_in_buf   = '0;
      m_out_buf  = '0;
      m_in_full  = 1'b0;
      m_out_full = 1'b0;
    end else begin
      drain_in = nicEn && !nicWrEn && (addr == 2'b00) && m_in_full;
      take_in  = net_si && !m_in_full;
      wr_out   = nicEn && nicWrEn && (addr == 2'b10) && !m_out_full;
      send_out = exp_so();
      if (drain_in) m_in_full = 1'b0;
      else if (take_in) begin
        m_in_buf  = net_di;
        m_in_full = 1'b1;
      end
      if (send_out) m_out_full = 1'b0;
      else if (wr_out) begin
        m_out_buf  = d_in;
        m_out_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_net_ri", 64'(net_ri), 64'(!m_in_full));
      check("cyc_net_so", 64'(net_so), 64'(exp_so()));
      check("cyc_net_do", net_do, m_out_full ? m_out_buf : '0);
      check("cyc_d_out", d_out, exp_dout());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit sent;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // 1: reset mid-operation with a pending outbound word and router ready
    nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h0000_0000_0000_00F0;
    step();
    nicWrEn = 0; addr = 2'b11;
    #1 check("t1_out_stat_pre", d_out, 64'd1);
    net_ro = 1;
    #1 reset = 1'b1;
    #1;
    check("t1_so_rst", 64'(net_so), 64'd0);
    check("t1_ri_rst", 64'(net_ri), 64'd1);
    check("t1_dout_rst", d_out, 64'd0);
    check("t1_do_rst", net_do, 64'd0);
    step();
    reset = 1'b0; net_ro = 0;
    #1 check("t1_out_stat_post", d_out, 64'd0);
    addr = 2'b01;
    #1 check("t1_in_stat_post", d_out, 64'd0);
    nicEn = 0;

    // 2: router delivers one packet, processor reads and drains it
    net_si = 1; net_di = 64'hDEAD_BEEF_0000_0001;
    step();
    net_si = 0;
    #1 check("t2_ri_full", 64'(net_ri), 64'd0);
    nicEn = 1; nicWrEn = 0; addr = 2'b01;
    #1 check("t2_in_stat", d_out, 64'd1);
    addr = 2'b00;
    #1 check("t2_in_buf", d_out, 64'hDEAD_BEEF_0000_0001);
    step();
    nicEn = 0;
    #1 check("t2_ri_free", 64'(net_ri), 64'd1);
    nicEn = 1; addr = 2'b01;
    #1 check("t2_in_stat_empty", d_out, 64'd0);
    nicEn = 0;

    // 3: outbound packet with VC bit set leaves only on polarity 1
    net_ro = 1;
    nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h8000_0000_0000_00AA;
    step();
    nicEn = 0; nicWrEn = 0;
    sent = 0;
    for (int i = 0; i < 3 && !sent; i++) begin
      #1;
      check("t3_so_vs_pol", 64'(net_so), 64'(net_polarity));
      check("t3_do", net_do, 64'h8000_0000_0000_00AA);
      if (net_polarity) sent = 1;
      else step();
    end
    if (!sent) check("t3_sent", 64'd0, 64'd1);
    step();
    nicEn = 1; addr = 2'b11;
    #1 check("t3_out_stat_clear", d_out, 64'd0);
    nicEn = 0; net_ro = 0;

    // 4: write while full is dropped
    nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h0000_0000_0000_5555;
    step();
    d_in = 64'h0000_0000_0000_1234;
    step();
    nicWrEn = 0; addr = 2'b11;
    #1;
    check("t4_out_buf_kept", net_do, 64'h0000_0000_0000_5555);
    check("t4_out_stat", d_out, 64'd1);
    nicEn = 0; net_ro = 1;
    repeat (3) step();
    net_ro = 0;

    // 5: router holds a second packet while the first is being drained
    net_si = 1; net_di = 64'h0000_0000_0000_1111;
    step();
    net_di = 64'h0000_0000_0000_2222;
    nicEn = 1; nicWrEn = 0; addr = 2'b00;
    #1;
    check("t5_first_pkt", d_out, 64'h0000_0000_0000_1111);
    check("t5_ri_busy", 64'(net_ri), 64'd0);
    step();
    nicEn = 0;
    #1 check("t5_ri_after_drain", 64'(net_ri), 64'd1);
    step();
    net_si = 0; nicEn = 1; addr = 2'b01;
    #1;
    check("t5_in_stat", d_out, 64'd1);
    check("t5_ri_refull", 64'(net_ri), 64'd0);
    addr = 2'b00;
    #1 check("t5_second_pkt", d_out, 64'h0000_0000_0000_2222);
    step();
    nicEn = 0;

    // 6: send and write on the same edge, then a back-to-back write
    nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h8000_0000_0000_0001;
    step();
    nicEn = 0;
    #1;
    if (!net_polarity) begin
      step();
      #1;
    end
    net_ro = 1; nicEn = 1; d_in = 64'h0000_0000_0000_0002;
    #1;
    check("t6_so_same_edge", 64'(net_so), 64'd1);
    check("t6_do_old", net_do, 64'h8000_0000_0000_0001);
    step();
    d_in = 64'h0000_0000_0000_0003; net_ro = 0;
    #1;
    check("t6_so_after", 64'(net_so), 64'd0);
    check("t6_do_empty", net_do, 64'd0);
    step();
    nicWrEn = 0; addr = 2'b11;
    #1;
    check("t6_out_stat", d_out, 64'd1);
    check("t6_do_new", net_do, 64'h0000_0000_0000_0003);
    nicEn = 0;

    // Randomized traffic, including occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      nicEn   = ($urandom_range(0, 3) != 0);
      nicWrEn = 1'($urandom_range(0, 1));
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom, $urandom};
      net_si  = ($urandom_range(0, 2) != 0);
      net_di  = {$urandom, $urandom};
      net_ro  = 1'($urandom_range(0, 1));
    end
    step();
    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nic_interface.md
Name: nic_interface

Overview:
- Network interface controller between the four-stage processor's NIC port and the local mesh router port.
- Processor side: 2-bit addressed register window.
  - 00 input channel buffer (read)
  - 01 input status (read)
  - 10 output channel buffer (write)
  - 11 output status (read)
- Router side: one-entry input buffer and one-entry output buffer, each with a send/ready handshake.
- Outbound packets are injected only on the router's matching virtual-channel polarity.

Parameters:
DATA_WIDTH, 64, packet/data word width
ADDR_WIDTH, 2, processor register-window address width
VC_BIT, 0, bit index of the packet virtual-channel bit compared against net_polarity

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
addr  in  2  processor register address [0:1]
d_in  in  64  processor write data [0:63]
d_out  out  64  processor read data [0:63]
nicEn  in  1  processor access enable
nicWrEn  in  1  processor write enable (valid only with nicEn)
net_si  in  1  router send into NIC
net_ri  out  1  NIC ready to accept from router
net_di  in  64  router-to-NIC packet
net_so  out  1  NIC send to router
net_ro  in  1  router ready to accept from NIC
net_do  out  64  NIC-to-router packet
net_polarity  in  1  router cycle polarity (toggles every clk)

Behaviour:
- Reset (async, immediate, mid-transfer included):
  - in_buf=0, in_full=0, out_buf=0, out_full=0.
  - Hence net_ri=1, net_so=0, net_do=0, d_out=0.
- Processor read, combinational (nicEn=1, nicWrEn=0); same cycle, no latency:
  - addr 00: d_out=in_buf.
  - addr 01: d_out={63'b0,in_full}.
  - addr 11: d_out={63'b0,out_full}.
  - addr 10: d_out=0.
  - nicEn=0: d_out=0.
- Input buffer drain: on a clk edge with nicEn=1, nicWrEn=0, addr=00, in_full=1 → in_full<=0. in_buf keeps its value.
  - Read of 00 when empty → returns stale in_buf, no state change.
- Input fill: net_ri=~in_full.
  - On edge with net_si=1 and net_ri=1: in_buf<=net_di, in_full<=1.
  - net_si=1 while full: ignored; the router must hold.
- Simultaneous drain and router send while full: drain wins. Router is not accepted that cycle because net_ri=0 at the edge; it is accepted the next cycle.
- Output fill: on edge with nicEn=1, nicWrEn=1, addr=10, out_full=0: out_buf<=d_in, out_full<=1.
  - Write while out_full=1: dropped silently. Software must poll 11 first.
  - Writes to 00, 01, 11: ignored.
- Output send: net_so=out_full & net_ro & (out_buf[VC_BIT]==net_polarity), combinational. net_do=out_buf when out_full, else 0.
  - On edge with net_so=1: out_full<=0.
- Simultaneous send and processor write: the write sees out_full=1 at the edge and is dropped; out_full clears.
- Back-to-back: a write on the cycle after the send is accepted.
- Minimum latencies:
  - Router accept → status 01 reads 1: 1 cycle.
  - Processor write → net_so eligible: 1 cycle, then waits for matching polarity (≤1 extra cycle when net_ro=1).
- No state machines beyond the two full flags; each channel is a 2-state EMPTY/FULL machine.

Decomposition:
- Shared package (nic_pkg):
  - NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11.
  - DATA_WIDTH and VC_BIT defaults.
  - Status-word construction constant.
- One sub-module: nic_channel_buffer.
  - One-entry register plus full flag, with load/drain strobes and async reset.
  - Instantiated twice: input and output channels.

Test Plan:
1. Assert reset mid-operation with out_full=1, net_ro=1 → same cycle net_so=0, net_ri=1, d_out=0; status 01 and 11 read 0 after release.
2. Router sends net_di=64'hDEAD_BEEF_0000_0001 → next cycle net_ri=0 and addr01 reads 1. Read addr00 returns the packet. After that edge, net_ri=1 and addr01 reads 0.
3. Processor writes 64'h8000_0000_0000_00AA (VC bit=1) to addr10 with net_ro=1 → net_so asserts only in the cycle with net_polarity=1; net_do equals the packet; out_full clears next edge.
4. With out_full=1 and net_ro=0, write 64'h1234 to addr10 → write dropped; out_buf unchanged; addr11 reads 1.
5. With in_full=1, hold net_si=1 with a new packet while the processor reads addr00 → first packet is returned. The second packet is latched one cycle later, and addr01 reads 1 again.
6. Same-edge send and write to addr10 → old packet transmitted, new write dropped. A write the following cycle succeeds and addr11 reads 1.
